// File: rtl/imem_boot_loader.sv
// Byte-serial boot loader: receives a framed program image, writes it into instruction memory,
// and holds the CPU in reset until the image checksum verifies.
module imem_boot_loader #(
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_rst,
   output logic              done,
   output logic              err
);

   localparam int unsigned MaxWords = 1 << ADDR_W;

   typedef enum logic [2:0] {
      StHdrLo,
      StHdrHi,
      StData,
      StCsum,
      StRun,
      StErr
   } state_e;

   state_e            state_q, state_d;
   logic [15:0]       n_q, n_d;
   logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
   logic [1:0]        byte_idx_q, byte_idx_d;
   logic [7:0]        csum_q, csum_d;
   logic [23:0]       lanes_q, lanes_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;

   logic        accept;
   logic [15:0] n_full;

   assign in_ready = (state_q == StHdrLo) || (state_q == StHdrHi) ||
                     (state_q == StData)  || (state_q == StCsum);
   assign accept   = in_valid & in_ready;
   assign n_full   = {in_data, n_q[7:0]};

   assign imem_we    = we_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign done       = (state_q == StRun);
   assign err        = (state_q == StErr);
   assign cpu_rst    = (state_q != StRun);

   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      word_cnt_d = word_cnt_q;
      byte_idx_d = byte_idx_q;
      csum_d     = csum_q;
      lanes_d    = lanes_q;
      we_d       = 1'b0;
      addr_d     = addr_q;
      wdata_d    = wdata_q;

      case (state_q)
         StHdrLo: begin
            if (accept) begin
               n_d[7:0] = in_data;
               state_d  = StHdrHi;
            end
         end
         StHdrHi: begin
            if (accept) begin
               n_d        = n_full;
               word_cnt_d = '0;
               byte_idx_d = 2'd0;
               csum_d     = 8'h00;
               if ((n_full == 16'd0) || (32'(n_full) > MaxWords)) begin
                  state_d = StErr;
               end else begin
                  state_d = StData;
               end
            end
         end
         StData: begin
            if (accept) begin
               csum_d = csum_q ^ in_data;
               if (byte_idx_q == 2'd3) begin
                  // Assembly lanes stay separate from wdata so the next byte can land while we pulses.
                  we_d       = 1'b1;
                  addr_d     = word_cnt_q;
                  wdata_d    = {in_data, lanes_q};
                  word_cnt_d = word_cnt_q + 1'b1;
                  byte_idx_d = 2'd0;
                  if (16'(word_cnt_q) == (n_q - 16'd1)) begin
                     state_d = StCsum;
                  end
               end else begin
                  case (byte_idx_q)
                     2'd0:    lanes_d[7:0]   = in_data;
                     2'd1:    lanes_d[15:8]  = in_data;
                     default: lanes_d[23:16] = in_data;
                  endcase
                  byte_idx_d = byte_idx_q + 2'd1;
               end
            end
         end
         StCsum: begin
            if (accept) begin
               state_d = (in_data == csum_q) ? StRun : StErr;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StHdrLo;
         n_q        <= 16'd0;
         word_cnt_q <= '0;
         byte_idx_q <= 2'd0;
         csum_q     <= 8'h00;
         lanes_q    <= 24'h0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= 32'h0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         word_cnt_q <= word_cnt_d;
         byte_idx_q <= byte_idx_d;
         csum_q     <= csum_d;
         lanes_q    <= lanes_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
      end
   end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: table of frames plus hand-written corner sequences,
// every cycle compared against a frame-level reference model.
module tb_imem_boot_loader;

   localparam int ADDR_W = 8;

   logic              clk;
   logic              rst;
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              cpu_rst;
   logic              done;
   logic              err;

   int checks = 0;
   int errors = 0;

   imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_rst    (cpu_rst),
      .done       (done),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] n_lo;
      logic [7:0] n_hi;
      bit         corrupt;
      bit         exp_err;
      bit         exp_done;
      int         exp_writes;
      int         gap_pct;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
      chk({tag, " imem_we"}, 32'(imem_we), 32'd0);
      chk({tag, " imem_addr"}, 32'(imem_addr), 32'd0);
      chk({tag, " imem_wdata"}, imem_wdata, 32'd0);
      chk({tag, " cpu_rst"}, 32'(cpu_rst), 32'd1);
      chk({tag, " done"}, 32'(done), 32'd0);
      chk({tag, " err"}, 32'(err), 32'd0);
   endtask

   // Called at posedge+1; releases reset before the next rising edge.
   task automatic do_reset();
      in_valid = 1'b0;
      rst      = 1'b0;
      #2;
      rst      = 1'b1;
   endtask

   // Build a frame: header, 4N random payload bytes, checksum (optionally corrupted), 3 extras.
   task automatic build_frame(input logic [7:0] lo, input logic [7:0] hi, input bit corrupt,
                              output logic [7:0] fr[$]);
      int         n;
      logic [7:0] cs;
      logic [7:0] b;
      fr.delete();
      fr.push_back(lo);
      fr.push_back(hi);
      n  = int'({hi, lo});
      cs = 8'h00;
      if (n != 0 && n <= (1 << ADDR_W)) begin
         for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            cs ^= b;
            fr.push_back(b);
         end
         if (corrupt) cs ^= 8'(1 << $urandom_range(7));
         fr.push_back(cs);
      end
      for (int i = 0; i < 3; i++) fr.push_back(8'($urandom));
   endtask

   // Drive a byte stream and compare every cycle against what the frame rules predict.
   task automatic run_frame(input logic [7:0] fr[$], input int gap_pct, output int n_writes);
      int         n;
      bit         bad;
      bit         ok;
      int         end_idx;
      logic [7:0] cs;
      bit         completes;
      int         w;
      logic [31:0] word;
      bit         fin;
      n        = int'({fr[1], fr[0]});
      bad      = (n == 0) || (n > (1 << ADDR_W));
      end_idx  = bad ? 1 : 4 * n + 2;
      cs       = 8'h00;
      if (!bad) for (int i = 2; i < 4 * n + 2; i++) cs ^= fr[i];
      ok       = !bad && (fr[end_idx] == cs);
      n_writes = 0;
      for (int j = 0; j < fr.size(); j++) begin
         for (int g = 0; g < 3 && int'($urandom_range(99)) < gap_pct; g++) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(posedge clk);
            #1;
            chk("gap we", 32'(imem_we), 32'd0);
         end
         in_valid = 1'b1;
         in_data  = fr[j];
         @(posedge clk);
         #1;
         in_valid  = 1'b0;
         completes = !bad && j >= 2 && j < 4 * n + 2 && ((j - 2) % 4 == 3);
         if (imem_we) n_writes++;
         chk("we", 32'(imem_we), 32'(completes));
         if (completes) begin
            w    = (j - 2) / 4;
            word = {fr[j], fr[j - 1], fr[j - 2], fr[j - 3]};
            chk("addr", 32'(imem_addr), 32'(w));
            chk("wdata", imem_wdata, word);
         end
         fin = (j >= end_idx);
         chk("in_ready", 32'(in_ready), 32'(!fin));
         chk("done", 32'(done), 32'(fin && ok));
         chk("err", 32'(err), 32'(fin && !ok));
         chk("cpu_rst", 32'(cpu_rst), 32'(!(fin && ok)));
      end
   endtask

   vec_t       vecs[7];
   logic [7:0] fr[$];
   int         nw;

   initial begin
      vecs[0] = '{8'h01, 8'h00, 1'b0, 1'b0, 1'b1, 1, 0};
      vecs[1] = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 0, 30};
      vecs[2] = '{8'h01, 8'h01, 1'b0, 1'b1, 1'b0, 0, 0};
      vecs[3] = '{8'h03, 8'h00, 1'b1, 1'b1, 1'b0, 3, 40};
      vecs[4] = '{8'h05, 8'h00, 1'b0, 1'b0, 1'b1, 5, 50};
      vecs[5] = '{8'h00, 8'h01, 1'b0, 1'b0, 1'b1, 256, 0};
      vecs[6] = '{8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 255, 20};

      rst      = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("por");
      rst = 1'b1;

      // N=1 known frame, continuous valid.
      fr = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB6, 8'h55};
      run_frame(fr, 0, nw);
      chk("n1 writes", 32'(nw), 32'd1);
      chk("n1 wdata", imem_wdata, 32'h00A00513);
      chk("n1 done", 32'(done), 32'd1);
      chk("n1 cpu_rst", 32'(cpu_rst), 32'd0);

      // N=2 known frame with gaps.
      do_reset();
      fr = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h33, 8'h81, 8'h10, 8'h00, 8'h61};
      run_frame(fr, 50, nw);
      chk("n2 writes", 32'(nw), 32'd2);
      chk("n2 addr", 32'(imem_addr), 32'd1);
      chk("n2 wdata", imem_wdata, 32'h00108133);
      chk("n2 done", 32'(done), 32'd1);

      // Reset mid-frame after 2 payload bytes, starting from a post-load state.
      fr = '{8'h01, 8'h00, 8'h13, 8'h05};
      do_reset();
      for (int j = 0; j < fr.size(); j++) begin
         in_valid = 1'b1;
         in_data  = fr[j];
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      rst      = 1'b0;
      #1;
      chk_reset_vals("midrst");
      #2;
      rst = 1'b1;
      fr  = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB6};
      run_frame(fr, 0, nw);
      chk("midrst addr", 32'(imem_addr), 32'd0);
      chk("midrst wdata", imem_wdata, 32'h00A00513);
      chk("midrst cpu_rst", 32'(cpu_rst), 32'd0);

      // Wrong checksum on the N=1 frame.
      do_reset();
      fr = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB7, 8'hB6};
      run_frame(fr, 0, nw);
      chk("badcs writes", 32'(nw), 32'd1);
      chk("badcs wdata", imem_wdata, 32'h00A00513);
      chk("badcs err", 32'(err), 32'd1);
      chk("badcs done", 32'(done), 32'd0);
      chk("badcs cpu_rst", 32'(cpu_rst), 32'd1);

      for (int v = 0; v < 7; v++) begin
         do_reset();
         build_frame(vecs[v].n_lo, vecs[v].n_hi, vecs[v].corrupt, fr);
         run_frame(fr, vecs[v].gap_pct, nw);
         chk($sformatf("vec%0d writes", v), 32'(nw), 32'(vecs[v].exp_writes));
         chk($sformatf("vec%0d done", v), 32'(done), 32'(vecs[v].exp_done));
         chk($sformatf("vec%0d err", v), 32'(err), 32'(vecs[v].exp_err));
         if (vecs[v].exp_writes > 0)
            chk($sformatf("vec%0d last addr", v), 32'(imem_addr), 32'(vecs[v].exp_writes - 1));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Byte-serial boot loader directly upstream of the single-cycle RISC-V `top`. It receives a framed program image over a valid/ready byte stream, assembles little-endian 32-bit instructions, and writes them into instruction memory through a write port. It holds the CPU in reset (`cpu_rst`, which drives `top.rst`) until the whole image has loaded and its checksum has verified. It then releases the CPU to execute from address 0.

## Interface
Parameters:
- `ADDR_W`, 8, instruction-memory word-address width; capacity is 2^ADDR_W words.

Ports:
- `clk`  input  1  system clock, rising-edge.
- `rst`  input  1  reset, asynchronous, active-low.
- `in_valid`  input  1  `in_data` is valid this cycle.
- `in_data`  input  8  stream byte.
- `in_ready`  output  1  loader can accept a byte; a transfer occurs on a rising edge with `in_valid & in_ready`.
- `imem_we`  output  1  instruction-memory write strobe, one cycle per word.
- `imem_addr`  output  ADDR_W  word address of the write.
- `imem_wdata`  output  32  instruction word.
- `cpu_rst`  output  1  active-high reset to `top`.
- `done`  output  1  image loaded and verified.
- `err`  output  1  load failed, sticky.

## Operation
- Frame format: `N_lo`, `N_hi`, then 4·N payload bytes, then 1 checksum byte.
  - N is an unsigned 16-bit word count.
  - Payload words are little-endian: the first byte maps to [7:0].
  - Checksum = XOR of all payload bytes. Header bytes are excluded.
- States are HDR_LO, HDR_HI, DATA, CSUM, RUN and ERR. Reset enters HDR_LO.
- HDR_LO: accepts a byte, latches it into N[7:0], and moves to HDR_HI.
- HDR_HI: accepts a byte and latches it into N[15:8].
  - If the full N is 0 or N > 2^ADDR_W, go to ERR.
  - Otherwise go to DATA, with word counter = 0, byte index = 0, and checksum accumulator = 0.
- DATA: each accepted byte goes into assembly lane [byte index] and is XORed into the accumulator.
  - On the 4th byte, register the word for writing, increment the word counter, and reset the byte index.
  - After word N−1 completes, go to CSUM.
- CSUM: accepts one byte.
  - If it equals the accumulator, go to RUN.
  - Otherwise go to ERR.
- RUN: `done`=1, `cpu_rst`=0, `in_ready`=0. Further bytes are ignored. Exit is only by `rst`.
- ERR: `err`=1, `cpu_rst`=1, `in_ready`=0. Exit is only by `rst`.
- `in_ready` = 1 in HDR_LO, HDR_HI, DATA and CSUM. It is a pure function of state; there is no back-pressure during writes.
- The assembly register is separate from the `imem_wdata` register. A byte arriving in the same cycle as a write strobe is accepted normally.
- `in_data` is ignored whenever `in_valid`=0 or `in_ready`=0.

## Timing
- Reset values: `in_ready`=1, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_rst`=1, `done`=0, `err`=0.
  - All of these take effect asynchronously on `rst` falling.
- Write latency: if a word's 4th byte is accepted at edge k, then during cycle k..k+1:
  - `imem_we`=1;
  - `imem_addr` = word index;
  - `imem_wdata` = assembled word.
  - `imem_we` is a single-cycle pulse.
  - `imem_addr` and `imem_wdata` hold until the next write.
- Throughput: 1 byte per cycle. With `in_valid` held high, a frame takes 4N+3 edges.
- `cpu_rst` falls, and `done` rises, on the edge that accepts a correct checksum byte.
- `err` rises on the edge that accepts the failing `N_hi` byte or the failing checksum byte.
- Wrap-around: `imem_addr` never wraps, because N ≤ 2^ADDR_W is enforced. The last address is 2^ADDR_W−1.
- Reset mid-operation:
  - All state clears and `cpu_rst` reasserts immediately.
  - Memory words already written are not undone.
  - The next frame rewrites from address 0.
- `rst` deassertion is sampled synchronously. The first byte can be accepted at the first rising edge after `rst` goes high.

## Test plan
- N=1 frame `01 00 13 05 A0 00 B6`, `in_valid` continuous:
  - one `imem_we` pulse with addr 0 and wdata 0x00A00513;
  - `cpu_rst` falls and `done`=1 after the 7th byte;
  - `in_ready`=0 afterwards.
- N=2 frame with random `in_valid` gaps, words 0x00500093 and 0x00108133, correct checksum:
  - writes to addr 0 then addr 1 with exact data;
  - no write during gaps;
  - `done`=1.
- Same N=1 frame with checksum 0xB7:
  - no release: `err`=1, `cpu_rst` stays 1, `done`=0, `in_ready`=0;
  - the one word is still written.
- Header `00 00`: `err`=1 on the `N_hi` edge and no `imem_we` ever. Header `01 01` (N=257, ADDR_W=8): `err`=1 likewise.
- N=256 max frame: 256 writes with `imem_addr` 0..255 in order; `done`=1; no address wrap.
- `rst` pulsed low after 2 payload bytes of an N=1 frame:
  - outputs immediately at reset values;
  - a fresh full frame then writes addr 0 with the correct word and releases `cpu_rst`.
